cp0_reg_file: RTL and testbench

//  Coprocessor-0 register block; consumer end of WB_CP0_Interface (CP0 modport), driven by the WB stage.

---
 rtl/cp0_reg_file.sv | 85 ++++++++
 tb/tb_cp0_reg_file.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cp0_reg_file.sv
// cp0_reg_file: CP0 register block committing MTC0, exceptions and ERET at WB, with timer and interrupt request.
module cp0_reg_file #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_CP0Wr,
  input  logic [4:0]  WB_Dst,
  input  logic [31:0] WB_Result,
  input  logic [8:0]  WB_ExceptType,
  input  logic [31:0] WB_PC,
  input  logic        WB_IsInDelaySlot,
  input  logic [31:0] WB_ALUOut,
  input  logic [5:0]  Ext_Int,
  input  logic [4:0]  CP0_RdAddr,
  output logic [31:0] CP0_RdData,
  output logic        CP0_Flush,
  output logic [31:0] CP0_RedirectPC,
  output logic        CP0_IntReq,
  output logic [31:0] CP0_Status,
  output logic [31:0] CP0_Cause,
  output logic [31:0] CP0_EPC
);
  logic [31:0] badvaddr, count, compare, status, cause, epc;
  logic [31:0] status_n, cause_n, rd_val, dst_val, wmask, wnew;
  logic        tick, exc, eret, wr, ti_n, bad_pc, bad_alu;
  logic [4:0]  code;
  logic [8:0]  t;
  assign t = WB_ExceptType;
  assign exc = |{t[8:3], t[1:0]};
  assign eret = t == 9'b0_0000_0100;
  assign wr = WB_CP0Wr & ~|t;
  assign code = t[8] ? 5'h00 : t[7] ? 5'h04 : t[6] ? 5'h0a : t[5] ? 5'h0c :
                t[4] ? 5'h08 : t[3] ? 5'h09 : t[0] ? 5'h04 : 5'h05;
  assign bad_pc = ~t[8] & t[7];
  assign bad_alu = ~|t[8:3] & |t[1:0];
  assign rd_val = CP0_RdAddr == 5'd8  ? badvaddr : CP0_RdAddr == 5'd9  ? count :
                  CP0_RdAddr == 5'd11 ? compare  : CP0_RdAddr == 5'd12 ? status :
                  CP0_RdAddr == 5'd13 ? cause    : CP0_RdAddr == 5'd14 ? epc : 32'd0;
  assign dst_val = WB_Dst == 5'd8  ? badvaddr : WB_Dst == 5'd9  ? count :
                   WB_Dst == 5'd11 ? compare  : WB_Dst == 5'd12 ? status :
                   WB_Dst == 5'd13 ? cause    : WB_Dst == 5'd14 ? epc : 32'd0;
  assign wmask = WB_Dst == 5'd12 ? 32'h0000_FF03 : WB_Dst == 5'd13 ? 32'h0000_0300 :
                 (WB_Dst == 5'd9 || WB_Dst == 5'd11 || WB_Dst == 5'd14) ? 32'hFFFF_FFFF : 32'd0;
  assign wnew = (dst_val & ~wmask) | (WB_Result & wmask);
  assign CP0_RdData = (wr && WB_Dst == CP0_RdAddr) ? wnew : rd_val;
  assign CP0_Flush = ~rst & (exc | eret);
  assign CP0_RedirectPC = exc ? EXC_VECTOR : epc;
  assign CP0_IntReq = status[0] & ~status[1] & |(cause[15:8] & status[15:8]);
  assign CP0_Status = status;
  assign CP0_Cause = cause;
  assign CP0_EPC = epc;
  // Writing Compare acknowledges the timer even if Count matches this cycle
  assign ti_n = (wr && WB_Dst == 5'd11) ? 1'b0 : (count == compare) | cause[30];
  always_comb begin
    status_n = (wr && WB_Dst == 5'd12) ? wnew : status;
    status_n[1] = exc ? 1'b1 : eret ? 1'b0 : status_n[1];
    cause_n = (wr && WB_Dst == 5'd13) ? wnew : cause;
    cause_n[30] = ti_n;
    cause_n[15:10] = {Ext_Int[5] | ti_n, Ext_Int[4:0]};
    cause_n[6:2] = exc ? code : cause_n[6:2];
    cause_n[31] = (exc && !status[1]) ? WB_IsInDelaySlot : cause_n[31];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr <= 32'd0;
      count <= 32'd0;
      compare <= 32'd0;
      status <= STATUS_RST;
      cause <= 32'd0;
      epc <= 32'd0;
      tick <= 1'b0;
    end else begin
      tick <= (wr && WB_Dst == 5'd9) ? 1'b0 : ~tick;
      count <= (wr && WB_Dst == 5'd9) ? WB_Result : tick ? count + 32'd1 : count;
      compare <= (wr && WB_Dst == 5'd11) ? WB_Result : compare;
      status <= status_n;
      cause <= cause_n;
      epc <= (wr && WB_Dst == 5'd14) ? WB_Result :
             (exc && !status[1]) ? (WB_IsInDelaySlot ? WB_PC - 32'd4 : WB_PC) : epc;
      badvaddr <= (exc && bad_pc) ? WB_PC : (exc && bad_alu) ? WB_ALUOut : badvaddr;
    end
  end
endmodule

// File: tb/tb_cp0_reg_file.sv
// tb_cp0_reg_file: scoreboard bench for cp0_reg_file; expectations queued at drive time, drained against DUT outputs.
module tb_cp0_reg_file;
  logic        clk = 0, rst = 1;
  logic        WB_CP0Wr = 0, WB_IsInDelaySlot = 0;
  logic [4:0]  WB_Dst = 0, CP0_RdAddr = 0;
  logic [31:0] WB_Result = 0, WB_PC = 0, WB_ALUOut = 0;
  logic [8:0]  WB_ExceptType = 0;
  logic [5:0]  Ext_Int = 0;
  logic [31:0] CP0_RdData, CP0_RedirectPC, CP0_Status, CP0_Cause, CP0_EPC;
  logic        CP0_Flush, CP0_IntReq;
  localparam int S_FL = 32, S_RD = 33, S_IR = 34, S_ST = 35, S_CA = 36, S_EP = 37;
  localparam logic [31:0] VEC = 32'hBFC0_0380;
  typedef struct {string tag; int sel; logic [31:0] mask; logic [31:0] exp;} exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;
  logic [31:0] exp_bad = 0, c;

  cp0_reg_file dut (.clk(clk), .rst(rst), .WB_CP0Wr(WB_CP0Wr), .WB_Dst(WB_Dst), .WB_Result(WB_Result),
    .WB_ExceptType(WB_ExceptType), .WB_PC(WB_PC), .WB_IsInDelaySlot(WB_IsInDelaySlot), .WB_ALUOut(WB_ALUOut),
    .Ext_Int(Ext_Int), .CP0_RdAddr(CP0_RdAddr), .CP0_RdData(CP0_RdData), .CP0_Flush(CP0_Flush),
    .CP0_RedirectPC(CP0_RedirectPC), .CP0_IntReq(CP0_IntReq), .CP0_Status(CP0_Status),
    .CP0_Cause(CP0_Cause), .CP0_EPC(CP0_EPC));

  always #10 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [31:0] mask, input logic [31:0] exp);
    sb.push_back('{tag, sel, mask, exp});
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.sel < 32) CP0_RdAddr = 5'(e.sel);
      #1;
      o = e.sel < 32 ? CP0_RdData : e.sel == S_FL ? {31'd0, CP0_Flush} : e.sel == S_RD ? CP0_RedirectPC :
          e.sel == S_IR ? {31'd0, CP0_IntReq} : e.sel == S_ST ? CP0_Status : e.sel == S_CA ? CP0_Cause : CP0_EPC;
      chk(e.tag, o & e.mask, e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wb(input logic w, input logic [4:0] d, input logic [31:0] r, input logic [8:0] et,
                    input logic [31:0] pc, input logic ds, input logic [31:0] alu);
    WB_CP0Wr = w; WB_Dst = d; WB_Result = r; WB_ExceptType = et;
    WB_PC = pc; WB_IsInDelaySlot = ds; WB_ALUOut = alu;
  endtask

  task automatic idle();
    wb(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic eret(input logic [31:0] epc_exp, input string tag);
    wb(0, 0, 0, 9'h004, 32'h8000_7000, 0, 0);
    push({tag, "_fl"}, S_FL, 1, 1);
    push({tag, "_pc"}, S_RD, '1, epc_exp);
    drain();
    step();
    idle();
    push({tag, "_exl"}, S_ST, 2, 0);
    drain();
  endtask

  typedef struct {logic [8:0] et; logic [4:0] code; int src;} row_t;
  row_t tbl[15];

  initial begin
    tbl = '{'{9'h100, 5'h00, 0}, '{9'h180, 5'h00, 0}, '{9'h080, 5'h04, 1}, '{9'h0C0, 5'h04, 1},
            '{9'h040, 5'h0a, 0}, '{9'h060, 5'h0a, 0}, '{9'h020, 5'h0c, 0}, '{9'h030, 5'h0c, 0},
            '{9'h010, 5'h08, 0}, '{9'h018, 5'h08, 0}, '{9'h008, 5'h09, 0}, '{9'h00C, 5'h09, 0},
            '{9'h003, 5'h04, 2}, '{9'h002, 5'h05, 2}, '{9'h001, 5'h04, 2}};
    @(negedge clk);
    wb(0, 0, 0, 9'h020, 32'h8000_0100, 0, 0);
    step(); step();
    push("rst_flush", S_FL, 1, 0);
    push("rst_status", S_ST, '1, 32'h0040_0000);
    push("rst_cause", S_CA, '1, 0);
    push("rst_epc", S_EP, '1, 0);
    push("rst_count", 9, '1, 0);
    push("rst_intreq", S_IR, 1, 0);
    drain();
    idle();
    rst = 0;
    repeat (10) step();
    push("count10", 9, '1, 5);
    drain();
    wb(1, 9, 32'hFFFF_FFFF, 0, 0, 0, 0);
    push("byp_count", 9, '1, 32'hFFFF_FFFF);
    drain();
    step();
    idle();
    push("count_wr", 9, '1, 32'hFFFF_FFFF);
    drain();
    step(); step();
    push("count_wrap", 9, '1, 0);
    drain();
    wb(0, 0, 0, 9'h020, 32'h8000_1000, 1, 0);
    push("ov_flush", S_FL, 1, 1);
    push("ov_redir", S_RD, '1, VEC);
    drain();
    step();
    idle();
    push("ov_epc", 14, '1, 32'h8000_0FFC);
    push("ov_cause", S_CA, 32'h8000_007C, 32'h8000_0030);
    push("ov_exl", S_ST, 2, 2);
    drain();
    wb(0, 0, 0, 9'h010, 32'h8000_5000, 0, 0);
    push("sys_flush", S_FL, 1, 1);
    drain();
    step();
    idle();
    push("sys_epc", S_EP, '1, 32'h8000_0FFC);
    push("sys_cause", S_CA, 32'h8000_007C, 32'h8000_0020);
    drain();
    eret(32'h8000_0FFC, "eret1");
    wb(0, 0, 0, 9'h001, 32'h8000_2000, 0, 32'h8000_0003);
    push("rd_redir", S_RD, '1, VEC);
    drain();
    step();
    idle();
    exp_bad = 32'h8000_0003;
    push("rd_bad", 8, '1, exp_bad);
    push("rd_cause", S_CA, 32'h8000_007C, 32'h0000_0010);
    push("rd_epc", S_EP, '1, 32'h8000_2000);
    drain();
    eret(32'h8000_2000, "eret2");
    wb(1, 11, 32'h1234_5678, 9'h020, 32'h8000_4000, 0, 0);
    push("mtc0x_byp", 11, '1, 0);
    push("mtc0x_flush", S_FL, 1, 1);
    drain();
    step();
    idle();
    push("mtc0x_cmp", 11, '1, 0);
    drain();
    eret(32'h8000_4000, "eret3");
    foreach (tbl[i]) begin
      wb(0, 0, 0, tbl[i].et, 32'h8000_3000 + 32'(i * 16), 0, 32'h9000_0000 + 32'(i));
      push($sformatf("t%0d_flush", i), S_FL, 1, 1);
      push($sformatf("t%0d_redir", i), S_RD, '1, VEC);
      drain();
      step();
      if (tbl[i].src == 1) exp_bad = 32'h8000_3000 + 32'(i * 16);
      if (tbl[i].src == 2) exp_bad = 32'h9000_0000 + 32'(i);
      idle();
      push($sformatf("t%0d_code", i), S_CA, 32'h7C, {25'd0, tbl[i].code, 2'd0});
      push($sformatf("t%0d_exl", i), S_ST, 2, 2);
      push($sformatf("t%0d_epc", i), S_EP, '1, 32'h8000_3000 + 32'(i * 16));
      push($sformatf("t%0d_bad", i), 8, '1, exp_bad);
      drain();
      eret(32'h8000_3000 + 32'(i * 16), $sformatf("t%0d_eret", i));
    end
    CP0_RdAddr = 9;
    #1 c = CP0_RdData;
    wb(1, 11, c + 32'd4, 0, 0, 0, 0);
    step();
    wb(1, 12, 32'hFFFF_FF01, 0, 0, 0, 0);
    push("byp_status", 12, '1, 32'h0040_FF01);
    push("cmp_ti_clr", S_CA, 32'h4000_8000, 0);
    push("cmp_int_clr", S_IR, 1, 0);
    drain();
    step();
    idle();
    push("status_wr", S_ST, '1, 32'h0040_FF01);
    drain();
    for (int k = 0; k < 10 && !CP0_IntReq; k++) step();
    push("timer_ti", S_CA, 32'h4000_8000, 32'h4000_8000);
    push("timer_int", S_IR, 1, 1);
    drain();
    wb(1, 11, 32'hFFFF_0000, 0, 0, 0, 0);
    step();
    idle();
    push("ack_ti", S_CA, 32'h4000_8000, 0);
    push("ack_int", S_IR, 1, 0);
    drain();
    wb(1, 13, 32'hFFFF_FFFF, 0, 0, 0, 0);
    push("byp_cause", 13, 32'h0000_0300, 32'h0000_0300);
    drain();
    step();
    idle();
    push("sw_ip", S_CA, 32'h0000_FF00, 32'h0000_0300);
    push("sw_int", S_IR, 1, 1);
    drain();
    wb(1, 13, 0, 0, 0, 0, 0);
    step();
    idle();
    push("sw_int_clr", S_IR, 1, 0);
    drain();
    Ext_Int = 6'b000001;
    step();
    push("ext_ip", S_CA, 32'h0000_FC00, 32'h0000_0400);
    push("ext_int", S_IR, 1, 1);
    drain();
    Ext_Int = 0;
    step();
    push("ext_int_clr", S_IR, 1, 0);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
